// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared Q-format defaults, saturation limits and clamp helper
// Purpose : default Q-format parameters, MAX/MIN saturation constants as a
//           function of width, and the saturating clamp used by the datapath.
// Ports   : none (package).
// Note    : fxp_wide_t carries 2W+1-bit intermediates, so W is limited to 63.
package fxp_pkg;

  localparam int unsigned FXP_W_DEF     = 32;
  localparam int unsigned FXP_FRAC_DEF  = 16;
  localparam int unsigned FXP_CNT_W_DEF = 8;
  localparam int unsigned FXP_WIDE      = 128;

  typedef logic signed [FXP_WIDE-1:0] fxp_wide_t;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_t;

  function automatic fxp_wide_t fxp_max(input int unsigned w);
    return (fxp_wide_t'(1) <<< (w - 1)) - fxp_wide_t'(1);
  endfunction

  function automatic fxp_wide_t fxp_min(input int unsigned w);
    return -(fxp_wide_t'(1) <<< (w - 1));
  endfunction

  // Clamp a wide signed value into the w-bit two's complement range.
  function automatic fxp_wide_t fxp_sat(input fxp_wide_t x, input int unsigned w);
    if (x > fxp_max(w)) begin
      return fxp_max(w);
    end else if (x < fxp_min(w)) begin
      return fxp_min(w);
    end
    return x;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - 2W+1 -> W round/shift/clamp with overflow flag
// Purpose : scales a 2W+1-bit product sum by 2^-FRAC and saturates to W bits.
//           Macro FXP_CMAC_ROUND_EN: defined -> round-half-up (bias 2^(FRAC-1));
//           undefined -> truncation toward minus infinity.
// Ports   : i_x   [2W:0] signed wide input
//           o_y   [W-1:0] signed scaled, saturated result
//           o_ovf 1 when the clamp changed the value
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int unsigned W    = FXP_W_DEF,
  parameter int unsigned FRAC = FXP_FRAC_DEF
) (
  input  logic signed [2*W:0]  i_x,
  output logic signed [W-1:0]  o_y,
  output logic                 o_ovf
);

  fxp_wide_t w_ext;
  fxp_wide_t w_bias;
  fxp_wide_t w_sh;
  fxp_wide_t w_sat;

  assign w_ext = {{(FXP_WIDE-2*W-1){i_x[2*W]}}, i_x};

`ifdef FXP_CMAC_ROUND_EN
  assign w_bias = fxp_wide_t'(1) <<< (FRAC - 1);
`else
  assign w_bias = '0;
`endif

  assign w_sh  = (w_ext + w_bias) >>> FRAC;
  assign w_sat = fxp_sat(w_sh, W);

  assign o_y   = w_sat[W-1:0];
  // Any difference between clamped and unclamped value means saturation.
  assign o_ovf = (w_sat != w_sh);

endmodule

// File: rtl/fxp_complex_mac.sv
// rtl/fxp_complex_mac.sv - pipelined fixed-point complex multiply / MAC
// Purpose : (ar + j*ai) * (br + j*bi) in Q(W-FRAC).FRAC with saturation, either
//           as a standalone product or summed over a group into a dot product.
//           Rounding mode selected by macro FXP_CMAC_ROUND_EN (see fxp_round_sat).
// Ports   : clk, rst (sync, active high)
//           in_valid/in_ready, in_ar/in_ai/in_br/in_bi [W], in_acc, in_last
//           out_valid/out_ready, out_re/out_im [W], out_ovf, out_terms [CNT_W]
// Pipe    : S1 partial products, S2 combine + round/sat, S3 accumulate/output.
module fxp_complex_mac
  import fxp_pkg::*;
#(
  parameter int unsigned W     = FXP_W_DEF,
  parameter int unsigned FRAC  = FXP_FRAC_DEF,
  parameter int unsigned CNT_W = FXP_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_ar,
  input  logic signed [W-1:0] in_ai,
  input  logic signed [W-1:0] in_br,
  input  logic signed [W-1:0] in_bi,
  input  logic                in_acc,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic                out_ovf,
  output logic [CNT_W-1:0]    out_terms
);

  // Whole pipeline advances together; a held output stalls every stage.
  logic w_adv;
  logic r_out_valid;
  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv & ~rst;

  // ---------------- S1: partial products ----------------
  logic signed [2*W-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [2*W-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic                  r_s1_valid, r_s1_acc, r_s1_last;

  assign w_ar = {{W{in_ar[W-1]}}, in_ar};
  assign w_ai = {{W{in_ai[W-1]}}, in_ai};
  assign w_br = {{W{in_br[W-1]}}, in_br};
  assign w_bi = {{W{in_bi[W-1]}}, in_bi};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_acc   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_p_rr     <= '0;
      r_p_ii     <= '0;
      r_p_ri     <= '0;
      r_p_ir     <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_acc   <= in_acc;
      r_s1_last  <= in_last;
      r_p_rr     <= w_ar * w_br;
      r_p_ii     <= w_ai * w_bi;
      r_p_ri     <= w_ar * w_bi;
      r_p_ir     <= w_ai * w_br;
    end
  end

  // ---------------- S2: combine, round, saturate ----------------
  logic signed [2*W:0]   w_re_wide, w_im_wide;
  logic signed [W-1:0]   w_s2_re, w_s2_im;
  logic                  w_s2_ovf_re, w_s2_ovf_im;
  logic signed [W-1:0]   r_s2_re, r_s2_im;
  logic                  r_s2_valid, r_s2_acc, r_s2_last, r_s2_ovf;

  assign w_re_wide = {r_p_rr[2*W-1], r_p_rr} - {r_p_ii[2*W-1], r_p_ii};
  assign w_im_wide = {r_p_ri[2*W-1], r_p_ri} + {r_p_ir[2*W-1], r_p_ir};

  fxp_round_sat #(.W(W), .FRAC(FRAC)) u_rs_re (
    .i_x   (w_re_wide),
    .o_y   (w_s2_re),
    .o_ovf (w_s2_ovf_re)
  );

  fxp_round_sat #(.W(W), .FRAC(FRAC)) u_rs_im (
    .i_x   (w_im_wide),
    .o_y   (w_s2_im),
    .o_ovf (w_s2_ovf_im)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_acc   <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_re    <= '0;
      r_s2_im    <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_acc   <= r_s1_acc;
      r_s2_last  <= r_s1_last;
      r_s2_ovf   <= w_s2_ovf_re | w_s2_ovf_im;
      r_s2_re    <= w_s2_re;
      r_s2_im    <= w_s2_im;
    end
  end

  // ---------------- S3: accumulator FSM and output ----------------
  acc_state_t            r_state, w_state_next;
  logic signed [W-1:0]   r_acc_re, r_acc_im;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sticky;
  logic signed [W-1:0]   w_base_re, w_base_im;
  logic [CNT_W-1:0]      w_base_cnt, w_cnt_next;
  logic                  w_base_ovf, w_sticky_next;
  fxp_wide_t             w_sum_re_ext, w_sum_im_ext, w_sum_re_sat, w_sum_im_sat;
  logic                  w_s2_take;

  assign w_s2_take = w_adv & r_s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACC_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_s2_take && r_s2_acc) begin
      w_state_next = r_s2_last ? ACC_IDLE : ACC_ACCUM;
    end
  end

  // A group starts from zero whenever the FSM is idle.
  always_comb begin
    w_base_re  = '0;
    w_base_im  = '0;
    w_base_cnt = '0;
    w_base_ovf = 1'b0;
    if (r_state == ACC_ACCUM) begin
      w_base_re  = r_acc_re;
      w_base_im  = r_acc_im;
      w_base_cnt = r_cnt;
      w_base_ovf = r_sticky;
    end
  end

  assign w_sum_re_ext  = {{(FXP_WIDE-W){w_base_re[W-1]}}, w_base_re}
                       + {{(FXP_WIDE-W){r_s2_re[W-1]}}, r_s2_re};
  assign w_sum_im_ext  = {{(FXP_WIDE-W){w_base_im[W-1]}}, w_base_im}
                       + {{(FXP_WIDE-W){r_s2_im[W-1]}}, r_s2_im};
  assign w_sum_re_sat  = fxp_sat(w_sum_re_ext, W);
  assign w_sum_im_sat  = fxp_sat(w_sum_im_ext, W);
  assign w_cnt_next    = (w_base_cnt == '1) ? w_base_cnt : w_base_cnt + 1'b1;
  assign w_sticky_next = w_base_ovf | r_s2_ovf
                       | (w_sum_re_sat != w_sum_re_ext)
                       | (w_sum_im_sat != w_sum_im_ext);

  logic signed [W-1:0] r_out_re, r_out_im;
  logic                r_out_ovf;
  logic [CNT_W-1:0]    r_out_terms;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_cnt       <= '0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_ovf   <= 1'b0;
      r_out_terms <= '0;
    end else if (w_adv) begin
      r_out_valid <= 1'b0;
      if (r_s2_valid && !r_s2_acc) begin
        r_out_valid <= 1'b1;
        r_out_re    <= r_s2_re;
        r_out_im    <= r_s2_im;
        r_out_ovf   <= r_s2_ovf;
        r_out_terms <= CNT_W'(1);
      end else if (r_s2_valid && r_s2_last) begin
        r_out_valid <= 1'b1;
        r_out_re    <= w_sum_re_sat[W-1:0];
        r_out_im    <= w_sum_im_sat[W-1:0];
        r_out_ovf   <= w_sticky_next;
        r_out_terms <= w_cnt_next;
        r_acc_re    <= '0;
        r_acc_im    <= '0;
        r_cnt       <= '0;
        r_sticky    <= 1'b0;
      end else if (r_s2_valid) begin
        r_acc_re    <= w_sum_re_sat[W-1:0];
        r_acc_im    <= w_sum_im_sat[W-1:0];
        r_cnt       <= w_cnt_next;
        r_sticky    <= w_sticky_next;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_ovf   = r_out_ovf;
  assign out_terms = r_out_terms;

endmodule

// File: doc/fxp_complex_mac.md
# fxp_complex_mac

Pipelined, parametrised signed fixed-point complex multiply / multiply-accumulate unit for state-vector arithmetic: computes (ar + j·ai)·(br + j·bi) with rounding and saturation, and optionally sums a stream of such products into one dot-product result (one gate-matrix row times the amplitude vector). It generalises the scalar Q16.16 add/multiply blocks to arbitrary Q format, complex operands, accumulation and valid/ready flow control. It sits between the amplitude memory reader and the gate-application write-back.

## Interface
- W, 32, total operand/result width (two's complement)
- FRAC, 16, fractional bits (Q(W-FRAC).FRAC); 1 ≤ FRAC < W
- CNT_W, 8, width of term counter
---
- clk  in  1  clock
- rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- in_valid  in  1  input beat offered
- in_ready  out  1  unit accepts beat this cycle
- in_ar, in_ai, in_br, in_bi  in  W each  signed operand parts
- in_acc  in  1  1 = beat joins accumulation group; 0 = standalone product
- in_last  in  1  final term of group (meaningful only with in_acc=1)
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_re, out_im  out  W each  signed result
- out_ovf  out  1  saturation occurred anywhere in this result (sticky across group)
- out_terms  out  CNT_W  number of beats contributing (standalone = 1); saturates at 2^CNT_W-1

## Operation
- Transfer on in_valid & in_ready; output consumed on out_valid & out_ready.
- S1: register four 2W-bit products ar·br, ai·bi, ar·bi, ai·br.
- S2: re = ar·br − ai·bi, im = ar·bi + ai·br at 2W+1 bits; add 2^(FRAC-1) (see Configuration); arithmetic shift right FRAC; clamp to [−2^(W-1), 2^(W-1)−1]; per-part ovf flag.
- S3 standalone (in_acc=0): output = S2 result, out_terms=1, out_ovf = S2 ovf; accumulator untouched.
- S3 accumulate: acc_re/acc_im += S2 result at W+1 bits, clamped to W; sticky ovf |= S2 ovf | clamp; term counter +1 (saturating). On beat with in_last: present sum, then clear accumulator, sticky, counter. Non-last beats produce no output.
- Standalone beats may interleave inside a group; group state preserved.
- Accumulator states: IDLE (acc=0, cnt=0) → ACCUM on first in_acc beat reaching S3 → IDLE on in_last beat reaching S3.

## Timing
- Reset values: in_ready=0 during rst, out_valid=0, out_re=out_im=0, out_ovf=0, out_terms=0, all stage valids 0, accumulator/sticky/counter cleared; in_ready=1 the cycle after rst deasserts.
- Latency: 3 cycles from accepted beat to out_valid (standalone, or last beat of group).
- Throughput 1 beat/cycle when out_ready=1.
- Stall: adv = ~out_valid | out_ready; in_ready = adv & ~rst; all stages enable on adv only; bubbles propagate as valid=0.
- out_* held stable while out_valid & ~out_ready.
- rst mid-group or mid-stall: partial sum and in-flight beats discarded, no output.

## Configuration
- FXP_CMAC_ROUND_EN defined: round-half-up (add 2^(FRAC-1) before shift).
- Undefined: truncation toward −∞ (plain arithmetic shift); everything else identical.

## Structure
- Package fxp_pkg: Q-format parameters defaults, MAX/MIN saturation constants as functions of W, saturating-clamp function.
- Sub-module fxp_round_sat (2W+1 → W round/shift/clamp with ovf), instantiated twice in S2.

## Test plan (W=32, FRAC=16)
- Standalone (32768,0)·(32768,0) → out_re=16384, out_im=0, ovf=0, out_terms=1, out_valid exactly 3 cycles after accept.
- (0,65536)·(0,65536) → out_re=0xFFFF0000 (−1.0), out_im=0; (46341,0)·(46341,0) → out_re=32768.
- Rounding: (1,0)·(32768,0) → out_re=1 with FXP_CMAC_ROUND_EN, 0 without.
- Group of 3 beats (65536,0)·(65536,0), last on 3rd, with a standalone (32768,0)·(65536,0) between 1st and 2nd → outputs 32768 (terms=1) then 196608 (terms=3), in that order.
- Saturation: (0x7FFFFFFF,0)·(131072,0) → out_re=0x7FFFFFFF, ovf=1; group of two (0x40000000,0)·(65536,0) → 0x7FFFFFFF, ovf=1 sticky.
- Backpressure: out_ready=0 for 5 cycles while 6 beats offered → in_ready drops, outputs held stable, all 6 results delivered in order, none lost or duplicated; rst asserted mid-group → no output, next group sums from zero.
